// File: rtl/freq_generator_if.sv
// Control/status bundle for the programmable square-wave generator.
//
// Handshake: a request is a one-cycle `load` strobe carrying `freq_in`.
// It is taken only on a clock edge where `ready` is 1; a strobe while
// `ready` is 0 is dropped silently. An out-of-range request presented while
// `ready` is 1 is refused with a one-cycle `err` pulse and leaves `ready`
// high. There is no back-pressure beyond `ready`; the master must not
// assume a request was taken unless `ready` was 1 at the sampling edge.
interface freq_generator_if #(
  parameter int FREQ_WIDTH = 26
);
  logic [FREQ_WIDTH-1:0] freq_in;
  logic                  load;
  logic                  enable;
  logic                  ready;
  logic                  err;
  logic                  waveform;
  logic [FREQ_WIDTH-1:0] freq_active;
  logic                  dbg_state;

  modport master (
    output freq_in, load, enable,
    input  ready, err, waveform, freq_active, dbg_state
  );

  modport slave (
    input  freq_in, load, enable,
    output ready, err, waveform, freq_active, dbg_state
  );
endinterface

// File: rtl/freq_generator.sv
// Programmable 50 % duty square-wave source. A requested frequency is turned
// into a half-period count N = floor(CLK_FREQ / (2*freq_in)) by a bit-serial
// restoring divider, parked in a pending register, and applied only when the
// generator is stopped or at the end of a full period so the output never
// glitches.
module freq_generator #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int FREQ_WIDTH = $clog2(CLK_FREQ / 2)
) (
  input  logic           clk,
  input  logic           reset,
  freq_generator_if.slave bus
);
  localparam int D  = $clog2(CLK_FREQ + 1);
  localparam int IW = $clog2(D + 1);
  localparam int RW = FREQ_WIDTH + 2;
  localparam logic [D-1:0]          DIVIDEND = D'(CLK_FREQ);
  localparam logic [FREQ_WIDTH-1:0] F_MAX    = FREQ_WIDTH'(CLK_FREQ / 2);

  typedef enum logic {S_IDLE = 1'b0, S_DIVIDE = 1'b1} state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic [D-1:0]          sh_q, sh_d;        // dividend bits out, quotient bits in
  logic [RW-1:0]         rem_q, rem_d;
  logic [RW-1:0]         div_q, div_d;      // 2 * requested frequency
  logic [FREQ_WIDTH-1:0] f_lat_q, f_lat_d;
  logic [FREQ_WIDTH-1:0] n_pend_q, n_pend_d;
  logic [FREQ_WIDTH-1:0] f_pend_q, f_pend_d;
  logic                  pend_q, pend_d;
  logic [FREQ_WIDTH-1:0] n_act_q, n_act_d;
  logic [FREQ_WIDTH-1:0] f_act_q, f_act_d;
  logic [FREQ_WIDTH-1:0] cnt_q, cnt_d;
  logic                  wave_q, wave_d;

  logic [RW-1:0] rem_sh;
  logic [RW-1:0] rem_nx;
  logic [D-1:0]  quo_nx;
  logic          q_bit;
  logic          valid_req;
  logic          pend_write;
  logic          stopped;
  logic          at_end;
  logic          take;

  // Next-state logic: request validation, one divider step, pending/active
  // transfer and the half-period counter.
  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    err_d      = 1'b0;
    iter_d     = iter_q;
    sh_d       = sh_q;
    rem_d      = rem_q;
    div_d      = div_q;
    f_lat_d    = f_lat_q;
    n_pend_d   = n_pend_q;
    f_pend_d   = f_pend_q;
    pend_d     = pend_q;
    n_act_d    = n_act_q;
    f_act_d    = f_act_q;
    cnt_d      = cnt_q;
    wave_d     = wave_q;
    pend_write = 1'b0;

    // Restoring step: bring down the next dividend bit, subtract if it fits.
    rem_sh    = {rem_q[RW-2:0], sh_q[D-1]};
    q_bit     = (rem_sh >= div_q);
    rem_nx    = q_bit ? (rem_sh - div_q) : rem_sh;
    quo_nx    = {sh_q[D-2:0], q_bit};
    valid_req = (bus.freq_in != '0) && (bus.freq_in <= F_MAX);

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          if (valid_req) begin
            state_d = S_DIVIDE;
            ready_d = 1'b0;
            f_lat_d = bus.freq_in;
            div_d   = {1'b0, bus.freq_in, 1'b0};
            rem_d   = '0;
            sh_d    = DIVIDEND;
            iter_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DIVIDE: begin
        rem_d  = rem_nx;
        sh_d   = quo_nx;
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(D - 1)) begin
          state_d    = S_IDLE;
          ready_d    = 1'b1;
          pend_write = 1'b1;
          n_pend_d   = quo_nx[FREQ_WIDTH-1:0];
          f_pend_d   = f_lat_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    stopped = (f_act_q == '0) || !bus.enable;
    at_end  = (cnt_q == n_act_q - FREQ_WIDTH'(1));

    if (!bus.enable) begin
      wave_d = 1'b0;
      cnt_d  = '0;
    end else if (f_act_q != '0) begin
      if (at_end) begin
        wave_d = !wave_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + FREQ_WIDTH'(1);
      end
    end

    // A pending setting lands immediately when idle, otherwise on the 1->0
    // edge so the new period starts with a fresh low half.
    take = pend_q && (stopped || (wave_q && at_end));
    if (take) begin
      f_act_d = f_pend_q;
      n_act_d = n_pend_q;
      cnt_d   = '0;
      wave_d  = 1'b0;
    end

    if (pend_write) pend_d = 1'b1;
    else if (take)  pend_d = 1'b0;
  end

  // All state and outputs registered; reset aborts any division in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
      iter_q   <= '0;
      sh_q     <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      f_lat_q  <= '0;
      n_pend_q <= '0;
      f_pend_q <= '0;
      pend_q   <= 1'b0;
      n_act_q  <= '0;
      f_act_q  <= '0;
      cnt_q    <= '0;
      wave_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      err_q    <= err_d;
      iter_q   <= iter_d;
      sh_q     <= sh_d;
      rem_q    <= rem_d;
      div_q    <= div_d;
      f_lat_q  <= f_lat_d;
      n_pend_q <= n_pend_d;
      f_pend_q <= f_pend_d;
      pend_q   <= pend_d;
      n_act_q  <= n_act_d;
      f_act_q  <= f_act_d;
      cnt_q    <= cnt_d;
      wave_q   <= wave_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.err         = err_q;
  assign bus.waveform    = wave_q;
  assign bus.freq_active = f_act_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_freq_generator.sv
// Directed-plus-random bench for freq_generator. Expected half-period counts
// come from N = CLK_FREQ / (2*f) in plain integer arithmetic; the frequencies
// expected to reach freq_active are kept in order in exp_q.
module tb_freq_generator;
  localparam int CLK_FREQ = 100_000_000;
  localparam int FW       = 26;
  localparam int D        = 27;
  localparam int F_MAX    = CLK_FREQ / 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  freq_generator_if #(.FREQ_WIDTH(FW)) bus ();

  freq_generator #(.CLK_FREQ(CLK_FREQ), .FREQ_WIDTH(FW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [FW-1:0] exp_q[$];
  int cur_f = 0;

  // Scoreboard compare
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int half_n(input int f);
    return CLK_FREQ / (2 * f);
  endfunction

  // Drivers: advance one clock, sample/drive 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int f);
    bus.freq_in = FW'(f);
    bus.load    = 1'b1;
    tick();
    bus.load    = 1'b0;
  endtask

  // Counts cycles with ready low; optionally pulses a stray load mid-divide.
  task automatic wait_ready(output int lowc, input int stray_f);
    lowc = 0;
    while (bus.ready !== 1'b1 && lowc < 200) begin
      lowc++;
      if (lowc == 5 && stray_f != 0) begin
        bus.freq_in = FW'(stray_f);
        bus.load    = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      tick();
      if (lowc == 5 && stray_f != 0) chk("no_err_while_busy", bus.err, 0);
    end
    bus.load = 1'b0;
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (bus.waveform === v && n < 500) begin
      n++;
      tick();
    end
  endtask

  // Load a new frequency while the generator runs; the swap must land on 1->0.
  task automatic change_running(input int f_new, input int stray_f);
    int lowc, t, n;
    logic prev;
    logic hold_ok;
    t = 0;
    while (bus.waveform !== 1'b1 && t < 500) begin
      t++;
      tick();
    end
    chk("reach_high", bus.waveform, 1);
    repeat ($urandom_range(0, half_n(cur_f) - 1)) tick();
    exp_q.push_back(FW'(f_new));
    do_load(f_new);
    wait_ready(lowc, stray_f);
    chk("ready_low_run", lowc, D);
    prev    = bus.waveform;
    hold_ok = 1'b1;
    t       = 0;
    forever begin
      tick();
      t++;
      if (prev === 1'b1 && bus.waveform === 1'b0) break;
      if (bus.freq_active !== FW'(cur_f)) hold_ok = 1'b0;
      prev = bus.waveform;
      if (t > 1000) break;
    end
    chk("hold_old_until_fall", hold_ok, 1);
    chk("swap_at_fall", bus.freq_active, exp_q.pop_front());
    cur_f = f_new;
    run_len(1'b0, n);
    chk("new_low", n, half_n(f_new));
    run_len(1'b1, n);
    chk("new_high", n, half_n(f_new));
  endtask

  // Load while the generator is held off by enable=0, then release it.
  task automatic load_stopped(input int f);
    int lowc, n;
    bus.enable = 1'b0;
    tick();
    chk("wave_low_when_disabled", bus.waveform, 0);
    exp_q.push_back(FW'(f));
    do_load(f);
    wait_ready(lowc, 0);
    chk("ready_low_run", lowc, D);
    tick();
    chk("stopped_transfer", bus.freq_active, exp_q.pop_front());
    cur_f = f;
    repeat (3) tick();
    chk("still_low_disabled", bus.waveform, 0);
    bus.enable = 1'b1;
    run_len(1'b0, n);
    chk("enable_low", n, half_n(f));
    run_len(1'b1, n);
    chk("enable_high", n, half_n(f));
    run_len(1'b0, n);
    chk("enable_low2", n, half_n(f));
  endtask

  initial begin
    int lowc, n, fa;
    int bad_f[3];
    bus.freq_in = '0;
    bus.load    = 1'b0;
    bus.enable  = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_ready", bus.ready, 1);
    chk("rst_err", bus.err, 0);
    chk("rst_wave", bus.waveform, 0);
    chk("rst_freq_active", bus.freq_active, 0);

    // 1 MHz from a stopped generator with enable already high
    bus.enable = 1'b1;
    tick();
    exp_q.push_back(FW'(1_000_000));
    do_load(1_000_000);
    chk("ready_drops", bus.ready, 0);
    wait_ready(lowc, 0);
    chk("ready_low_1m", lowc, D);
    chk("not_yet_active", bus.freq_active, 0);
    tick();
    chk("active_1m", bus.freq_active, exp_q.pop_front());
    cur_f = 1_000_000;
    for (int p = 0; p < 2; p++) begin
      run_len(1'b0, n);
      chk("low_1m", n, 50);
      run_len(1'b1, n);
      chk("high_1m", n, 50);
    end

    // Running change with a stray load during the divide
    change_running(2_500_000, 7_000_000);
    change_running(4_219_409, 0);

    // Random running changes
    for (int i = 0; i < 4; i++) change_running($urandom_range(2_000_000, F_MAX), 0);

    // Rejected requests
    bad_f[0] = 0;
    bad_f[1] = F_MAX + 1;
    bad_f[2] = $urandom_range(F_MAX + 2, (1 << FW) - 1);
    for (int i = 0; i < 3; i++) begin
      fa = bus.freq_active;
      do_load(bad_f[i]);
      chk("err_pulse", bus.err, 1);
      chk("err_ready_high", bus.ready, 1);
      tick();
      chk("err_one_cycle", bus.err, 0);
      chk("err_active_kept", bus.freq_active, FW'(cur_f));
      if (fa != cur_f) chk("err_active_before", fa, cur_f);
    end
    run_len(bus.waveform, n);
    run_len(bus.waveform, n);
    chk("period_kept_after_err", n, half_n(cur_f));

    // Enable 0->1 restarts the low half; boundaries N=65 and N=1
    load_stopped(769_230);
    load_stopped(F_MAX);

    // Reset in the middle of a division
    do_load(3_000_000);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", bus.ready, 1);
    chk("mid_rst_active", bus.freq_active, 0);
    chk("mid_rst_wave", bus.waveform, 0);
    repeat (40) tick();
    chk("mid_rst_never_applied", bus.freq_active, 0);
    chk("mid_rst_wave_idle", bus.waveform, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
